reaction_round_ctrl: RTL and testbench

- Round controller and first-press arbiter for the two-player reaction game.
- Consumes the p1, p2 and space key levels from the PS/2 scan-code decoder. These levels live in the PS2_CLK domain.
- Sequences each round: space arms it, a random delay runs, then the GO light turns on.
- Arbitrates which player pressed first, flags early presses (fouls), measures reaction time and keeps per-player scores.

---
 rtl/game_pkg.sv | 26 ++
 rtl/key_sync_edge.sv | 25 ++
 rtl/reaction_round_ctrl.sv | 173 +++++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and constants for the reaction game round controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    GO     = 2'd2,
    RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an asynchronous key level plus a rising-edge pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic s1, s2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= key;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign press = s2 & ~prev;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer and first-press arbiter for the two-player reaction game.
module reaction_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned DELAY_MIN_TICKS = 1000,
  parameter int unsigned DELAY_BITS      = 11,
  parameter int unsigned TIMEOUT_TICKS   = 3000,
  parameter int unsigned HOLD_TICKS      = 2000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        p1_key,
  input  logic        p2_key,
  input  logic        space_key,
  output logic        go_led,
  output logic        busy,
  output logic [1:0]  winner,
  output logic [1:0]  foul,
  output logic [15:0] reaction_ticks,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2
);

  localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DCW = $clog2(DELAY_MIN_TICKS + (1 << DELAY_BITS) + 1);

  logic p1_press, p2_press, space_press;

  key_sync_edge u_sync_p1    (.clk(CLOCK_50), .rst(reset), .key(p1_key),    .press(p1_press));
  key_sync_edge u_sync_p2    (.clk(CLOCK_50), .rst(reset), .key(p2_key),    .press(p2_press));
  key_sync_edge u_sync_space (.clk(CLOCK_50), .rst(reset), .key(space_key), .press(space_press));

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DCW-1:0]  delay_q, delay_d;
  logic [15:0]     phase_q, phase_d;
  logic [1:0]      win_q, win_d;
  logic [1:0]      foul_q, foul_d;
  logic [15:0]     rt_q, rt_d;
  logic [3:0]      s1_q, s1_d, s2_q, s2_d;
  logic            tick, restart;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      presc_q <= '0;
      delay_q <= '0;
      phase_q <= '0;
      win_q   <= WIN_NONE;
      foul_q  <= '0;
      rt_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_next(lfsr_q);
      presc_q <= presc_d;
      delay_q <= delay_d;
      phase_q <= phase_d;
      win_q   <= win_d;
      foul_q  <= foul_d;
      rt_q    <= rt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    phase_d = phase_q;
    win_d   = win_q;
    foul_d  = foul_q;
    rt_d    = rt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    restart = 1'b0;
    presc_d = tick ? '0 : presc_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (space_press) begin
          state_d = WAIT;
          win_d   = WIN_NONE;
          foul_d  = '0;
          rt_d    = '0;
          delay_d = DCW'(DELAY_MIN_TICKS) + DCW'(lfsr_q[DELAY_BITS-1:0]);
          restart = 1'b1;
        end
      end
      WAIT: begin
        // Any press beats the delay expiring in the same cycle.
        if (p1_press || p2_press) begin
          state_d = RESULT;
          phase_d = '0;
          restart = 1'b1;
          foul_d  = {p2_press, p1_press};
          if (p1_press && p2_press) begin
            win_d = WIN_NONE;
          end else if (p1_press) begin
            win_d = WIN_P2;
            if (s2_q != 4'hF) s2_d = s2_q + 4'd1;
          end else begin
            win_d = WIN_P1;
            if (s1_q != 4'hF) s1_d = s1_q + 4'd1;
          end
        end else if (tick) begin
          if (delay_q <= DCW'(1)) begin
            state_d = GO;
            delay_d = '0;
            phase_d = '0;
            restart = 1'b1;
          end else begin
            delay_d = delay_q - DCW'(1);
          end
        end
      end
      GO: begin
        if (p1_press || p2_press) begin
          state_d = RESULT;
          phase_d = '0;
          restart = 1'b1;
          if (p1_press && p2_press) begin
            win_d = WIN_TIE;
          end else if (p1_press) begin
            win_d = WIN_P1;
            if (s1_q != 4'hF) s1_d = s1_q + 4'd1;
          end else begin
            win_d = WIN_P2;
            if (s2_q != 4'hF) s2_d = s2_q + 4'd1;
          end
        end else if (tick) begin
          if (rt_q != 16'hFFFF) rt_d = rt_q + 16'd1;
          if (phase_q == 16'(TIMEOUT_TICKS - 1)) begin
            state_d = RESULT;
            win_d   = WIN_NONE;
            phase_d = '0;
            restart = 1'b1;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
      end
      RESULT: begin
        if (tick) begin
          if (phase_q == 16'(HOLD_TICKS - 1)) begin
            state_d = IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) presc_d = '0;
  end

  assign go_led         = (state_q == GO);
  assign busy           = (state_q != IDLE);
  assign winner         = win_q;
  assign foul           = foul_q;
  assign reaction_ticks = rt_q;
  assign score_p1       = s1_q;
  assign score_p2       = s2_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed self-checking bench for reaction_round_ctrl with short tick settings.
module tb_reaction_round_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        p1_key = 1'b0, p2_key = 1'b0, space_key = 1'b0;
  logic        go_led, busy;
  logic [1:0]  winner, foul;
  logic [15:0] reaction_ticks;
  logic [3:0]  score_p1, score_p2;

  int checks = 0;
  int errors = 0;

  reaction_round_ctrl #(
    .TICK_DIV(4),
    .DELAY_MIN_TICKS(2),
    .DELAY_BITS(2),
    .TIMEOUT_TICKS(20),
    .HOLD_TICKS(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .p1_key(p1_key),
    .p2_key(p2_key),
    .space_key(space_key),
    .go_led(go_led),
    .busy(busy),
    .winner(winner),
    .foul(foul),
    .reaction_ticks(reaction_ticks),
    .score_p1(score_p1),
    .score_p2(score_p2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_busy(input logic want, input int limit, output int n);
    n = 0;
    while (busy !== want && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL wait_busy: busy=%b required %b within %0d cycles", busy, want, limit);
    end
  endtask

  task automatic wait_go(input int limit, output int n);
    n = 0;
    while (go_led !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (go_led !== 1'b1) begin
      errors++;
      $display("FAIL wait_go: go_led=%b required 1 within %0d cycles", go_led, limit);
    end
  endtask

  task automatic start_round();
    int n;
    space_key = 1'b1;
    wait_busy(1'b1, 6, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL start_latency: %0d cycles required 3", n);
    end
    space_key = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(100);
    checks++;
    if ({go_led, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: go_led/busy=%b required 00", {go_led, busy});
    end
    checks++;
    if ({winner, foul} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_result: winner/foul=%b required 0000", {winner, foul});
    end
    checks++;
    if (reaction_ticks !== 16'd0) begin
      errors++;
      $display("FAIL reset_rt: %0d required 0", reaction_ticks);
    end
    checks++;
    if ({score_p1, score_p2} !== 8'h00) begin
      errors++;
      $display("FAIL reset_scores: %h required 00", {score_p1, score_p2});
    end
  endtask

  task automatic test_normal_win();
    int n;
    int k;
    start_round();
    checks++;
    if (go_led !== 1'b0) begin
      errors++;
      $display("FAIL win_wait_go: go_led=%b required 0", go_led);
    end
    wait_go(30, n);
    checks++;
    if (n % 4 != 0 || n < 8 || n > 20) begin
      errors++;
      $display("FAIL win_delay: %0d cycles required 8/12/16/20", n);
    end
    k = 0;
    while (reaction_ticks !== 16'd3 && k < 20) begin
      step(1);
      k++;
    end
    checks++;
    if (reaction_ticks !== 16'd3) begin
      errors++;
      $display("FAIL win_rt_reach: %0d required 3", reaction_ticks);
    end
    p2_key = 1'b1;
    step(3);
    checks++;
    if (winner !== 2'b10 || reaction_ticks !== 16'd3 || score_p2 !== 4'd1 || score_p1 !== 4'd0) begin
      errors++;
      $display("FAIL win_result: winner=%b rt=%0d p1=%0d p2=%0d required 10 3 0 1",
               winner, reaction_ticks, score_p1, score_p2);
    end
    checks++;
    if ({go_led, busy} !== 2'b01) begin
      errors++;
      $display("FAIL win_result_flags: go_led/busy=%b required 01", {go_led, busy});
    end
    step(11);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL win_hold: busy=%b required 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0 || winner !== 2'b10 || reaction_ticks !== 16'd3) begin
      errors++;
      $display("FAIL win_idle: busy=%b winner=%b rt=%0d required 0 10 3",
               busy, winner, reaction_ticks);
    end
    p2_key = 1'b0;
    step(4);
  endtask

  task automatic test_foul();
    int n;
    logic saw_go;
    start_round();
    saw_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      saw_go |= go_led;
    end
    p1_key = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      saw_go |= go_led;
    end
    checks++;
    if (foul !== 2'b01 || winner !== 2'b10 || score_p2 !== 4'd2 || score_p1 !== 4'd0) begin
      errors++;
      $display("FAIL foul_result: foul=%b winner=%b p1=%0d p2=%0d required 01 10 0 2",
               foul, winner, score_p1, score_p2);
    end
    wait_busy(1'b0, 20, n);
    checks++;
    if (saw_go !== 1'b0) begin
      errors++;
      $display("FAIL foul_no_go: go_led seen=%b required 0", saw_go);
    end
    p1_key = 1'b0;
    step(4);
  endtask

  task automatic test_tie();
    int n;
    start_round();
    wait_go(30, n);
    p1_key = 1'b1;
    p2_key = 1'b1;
    step(3);
    checks++;
    if (winner !== 2'b11 || foul !== 2'b00 || score_p1 !== 4'd0 || score_p2 !== 4'd2) begin
      errors++;
      $display("FAIL tie_result: winner=%b foul=%b p1=%0d p2=%0d required 11 00 0 2",
               winner, foul, score_p1, score_p2);
    end
    wait_busy(1'b0, 20, n);
    p1_key = 1'b0;
    p2_key = 1'b0;
    step(4);
  endtask

  task automatic test_timeout();
    int n;
    start_round();
    wait_go(30, n);
    step(79);
    checks++;
    if (go_led !== 1'b1 || reaction_ticks !== 16'd19) begin
      errors++;
      $display("FAIL timeout_early: go_led=%b rt=%0d required 1 19", go_led, reaction_ticks);
    end
    step(1);
    checks++;
    if (go_led !== 1'b0 || busy !== 1'b1 || winner !== 2'b00 || reaction_ticks !== 16'd20) begin
      errors++;
      $display("FAIL timeout_result: go_led=%b busy=%b winner=%b rt=%0d required 0 1 00 20",
               go_led, busy, winner, reaction_ticks);
    end
    wait_busy(1'b0, 20, n);
    step(4);
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 1; i <= 16; i++) begin
      start_round();
      wait_go(30, n);
      p1_key = 1'b1;
      step(3);
      wait_busy(1'b0, 20, n);
      p1_key = 1'b0;
      step(4);
      if (i == 15) begin
        checks++;
        if (score_p1 !== 4'd15) begin
          errors++;
          $display("FAIL sat_reach: score_p1=%0d required 15", score_p1);
        end
      end
    end
    checks++;
    if (score_p1 !== 4'd15 || score_p2 !== 4'd2) begin
      errors++;
      $display("FAIL sat_hold: p1=%0d p2=%0d required 15 2", score_p1, score_p2);
    end
  endtask

  task automatic test_reset_mid_go();
    int n;
    start_round();
    wait_go(30, n);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (go_led !== 1'b0 || busy !== 1'b0 || score_p1 !== 4'd0 || score_p2 !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: go_led=%b busy=%b p1=%0d p2=%0d required 0 0 0 0",
               go_led, busy, score_p1, score_p2);
    end
    step(2);
    reset = 1'b0;
    step(2);
    start_round();
    wait_go(30, n);
    p2_key = 1'b1;
    step(3);
    checks++;
    if (winner !== 2'b10 || score_p2 !== 4'd1 || score_p1 !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_round: winner=%b p1=%0d p2=%0d required 10 0 1",
               winner, score_p1, score_p2);
    end
    wait_busy(1'b0, 20, n);
    p2_key = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_win();
    test_foul();
    test_tie();
    test_timeout();
    test_saturation();
    test_reset_mid_go();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
